// File: rtl/i2c_slave_regfile_pkg.sv
// Shared types for the I2C register-file target: FSM states, bit counter width
// and the read/write bit encoding used by the controller environment.
package i2c_slave_pkg;

    localparam int unsigned BIT_CNT_W = 4;

    typedef enum logic [3:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        PTR,
        PTR_ACK,
        WDATA,
        WDATA_ACK,
        RDATA,
        RDATA_ACK,
        IGNORE
    } i2c_slave_state_t;

    typedef enum logic {
        I2C_WRITE = 1'b0,
        I2C_READ  = 1'b1
    } i2c_rw_t;

endpackage

// File: rtl/i2c_slave_regfile_if.sv
// Open-drain I2C bus as seen by one target: sampled line levels in, drives out
// (0 = pull low, 1 = release).
interface i2c_slave_regfile_if;

    logic scl_i;
    logic sda_i;
    logic scl_o;
    logic sda_o;

    modport slave (
        input  scl_i,
        input  sda_i,
        output scl_o,
        output sda_o
    );

    modport master (
        output scl_i,
        output sda_i,
        input  scl_o,
        input  sda_o
    );

endinterface

// File: rtl/i2c_slave_regfile_bus_sync.sv
// Bus synchronizer: SYNC_STAGES flops per line, then registered one-cycle
// pulses for START, STOP, SCL rise and SCL fall. Usable by passive monitors.
module i2c_bus_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic scl_i,
    input  logic sda_i,
    output logic sda,
    output logic start,
    output logic stop,
    output logic scl_rise,
    output logic scl_fall
);

    logic [SYNC_STAGES-1:0] scl_sync;
    logic [SYNC_STAGES-1:0] sda_sync;
    logic                   scl_s;
    logic                   sda_s;
    logic                   scl_q;

    assign scl_s = scl_sync[SYNC_STAGES-1];
    assign sda_s = sda_sync[SYNC_STAGES-1];

    // Synchronize, keep previous sample, and flag conditions by comparing the two.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_q    <= 1'b1;
            sda      <= 1'b1;
            start    <= 1'b0;
            stop     <= 1'b0;
            scl_rise <= 1'b0;
            scl_fall <= 1'b0;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_i};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_i};
            scl_q    <= scl_s;
            sda      <= sda_s;
            scl_rise <= scl_s & ~scl_q;
            scl_fall <= ~scl_s & scl_q;
            start    <= scl_s & scl_q & sda & ~sda_s;
            stop     <= scl_s & scl_q & ~sda & sda_s;
        end
    end

endmodule

// File: rtl/i2c_slave_regfile.sv
// I2C target with a byte-wide register file behind an auto-incrementing pointer.
// Write: addr+W, pointer byte, data bytes. Read: addr+R, data bytes from pointer.
// Optional clock stretching after read ACK bits: define I2C_SLAVE_STRETCH_EN.
module i2c_slave_regfile
    import i2c_slave_pkg::*;
#(
    parameter int unsigned                I2C_ADDR_WIDTH = 7,
    parameter int unsigned                I2C_DATA_WIDTH = 8,
    parameter logic [I2C_ADDR_WIDTH-1:0]  SLAVE_ADDR     = 7'h22,
    parameter int unsigned                NUM_REGS       = 16,
    parameter int unsigned                SYNC_STAGES    = 2,
    parameter int unsigned                STRETCH_CYCLES = 20
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    i2c_slave_regfile_if.slave          bus,
    output logic                        busy_o,
    output logic                        wr_stb_o,
    output logic [$clog2(NUM_REGS)-1:0] wr_idx_o,
    output logic [I2C_DATA_WIDTH-1:0]   wr_dat_o
);

    localparam int unsigned            PTR_W     = $clog2(NUM_REGS);
    localparam int unsigned            STR_W     = $clog2(STRETCH_CYCLES + 1);
    localparam logic [BIT_CNT_W-1:0]   LAST_BIT  = BIT_CNT_W'(I2C_DATA_WIDTH - 1);
    localparam logic [BIT_CNT_W-1:0]   FRAME_END = BIT_CNT_W'(I2C_DATA_WIDTH);
`ifdef I2C_SLAVE_STRETCH_EN
    localparam bit                     STRETCH_EN = 1'b1;
`else
    localparam bit                     STRETCH_EN = 1'b0;
`endif

    logic                      sda;
    logic                      start;
    logic                      stop;
    logic                      scl_rise;
    logic                      scl_fall;

    i2c_slave_state_t          state;
    logic [BIT_CNT_W-1:0]      bit_cnt;
    logic [I2C_DATA_WIDTH-1:0] shreg;
    logic [I2C_DATA_WIDTH-1:0] txsh;
    logic [I2C_DATA_WIDTH-1:0] rx_byte;
    logic [I2C_DATA_WIDTH-1:0] regs [NUM_REGS];
    logic [PTR_W-1:0]          ptr;
    logic [PTR_W-1:0]          ptr_nxt;
    i2c_rw_t                   rw;
    logic                      mst_ack;
    logic                      sda_drv;
    logic                      scl_drv;
    logic [STR_W-1:0]          str_cnt;

    i2c_bus_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .scl_i    (bus.scl_i),
        .sda_i    (bus.sda_i),
        .sda      (sda),
        .start    (start),
        .stop     (stop),
        .scl_rise (scl_rise),
        .scl_fall (scl_fall)
    );

    assign rx_byte   = {shreg[I2C_DATA_WIDTH-2:0], sda};
    assign ptr_nxt   = ptr + PTR_W'(1);
    assign bus.sda_o = sda_drv;
    assign bus.scl_o = scl_drv;

    // Protocol FSM, register file and all registered outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state    <= IDLE;
            bit_cnt  <= '0;
            shreg    <= '0;
            txsh     <= '0;
            ptr      <= '0;
            rw       <= I2C_WRITE;
            mst_ack  <= 1'b1;
            sda_drv  <= 1'b1;
            scl_drv  <= 1'b1;
            str_cnt  <= '0;
            busy_o   <= 1'b0;
            wr_stb_o <= 1'b0;
            wr_idx_o <= '0;
            wr_dat_o <= '0;
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            wr_stb_o <= 1'b0;

            // SCL hold countdown; data for the next bit is already on SDA.
            if (!scl_drv) begin
                if (str_cnt != '0) begin
                    str_cnt <= str_cnt - STR_W'(1);
                end else begin
                    scl_drv <= 1'b1;
                end
            end

            if (start) begin
                state   <= ADDR;
                bit_cnt <= '0;
                sda_drv <= 1'b1;
                scl_drv <= 1'b1;
            end else if (stop) begin
                state   <= IDLE;
                bit_cnt <= '0;
                sda_drv <= 1'b1;
                scl_drv <= 1'b1;
                busy_o  <= 1'b0;
            end else begin
                case (state)
                    ADDR: begin
                        if (scl_rise) begin
                            shreg   <= rx_byte;
                            bit_cnt <= bit_cnt + BIT_CNT_W'(1);
                        end else if (scl_fall && bit_cnt == FRAME_END) begin
                            if (shreg[I2C_DATA_WIDTH-1 -: I2C_ADDR_WIDTH] == SLAVE_ADDR) begin
                                state   <= ADDR_ACK;
                                sda_drv <= 1'b0;
                                busy_o  <= 1'b1;
                                rw      <= i2c_rw_t'(shreg[0]);
                            end else begin
                                state <= IGNORE;
                            end
                        end
                    end

                    PTR: begin
                        if (scl_rise) begin
                            shreg   <= rx_byte;
                            bit_cnt <= bit_cnt + BIT_CNT_W'(1);
                            if (bit_cnt == LAST_BIT) begin
                                ptr <= PTR_W'(rx_byte);
                            end
                        end else if (scl_fall && bit_cnt == FRAME_END) begin
                            state   <= PTR_ACK;
                            sda_drv <= 1'b0;
                        end
                    end

                    WDATA: begin
                        if (scl_rise) begin
                            shreg   <= rx_byte;
                            bit_cnt <= bit_cnt + BIT_CNT_W'(1);
                            if (bit_cnt == LAST_BIT) begin
                                regs[ptr] <= rx_byte;
                                wr_stb_o  <= 1'b1;
                                wr_idx_o  <= ptr;
                                wr_dat_o  <= rx_byte;
                                ptr       <= ptr_nxt;
                            end
                        end else if (scl_fall && bit_cnt == FRAME_END) begin
                            state   <= WDATA_ACK;
                            sda_drv <= 1'b0;
                        end
                    end

                    ADDR_ACK: begin
                        if (scl_fall) begin
                            bit_cnt <= '0;
                            if (rw == I2C_READ) begin
                                state   <= RDATA;
                                sda_drv <= regs[ptr][I2C_DATA_WIDTH-1];
                                txsh    <= {regs[ptr][I2C_DATA_WIDTH-2:0], 1'b0};
                                if (STRETCH_EN) begin
                                    scl_drv <= 1'b0;
                                    str_cnt <= STR_W'(STRETCH_CYCLES - 1);
                                end
                            end else begin
                                state   <= PTR;
                                sda_drv <= 1'b1;
                            end
                        end
                    end

                    PTR_ACK, WDATA_ACK: begin
                        if (scl_fall) begin
                            state   <= WDATA;
                            bit_cnt <= '0;
                            sda_drv <= 1'b1;
                        end
                    end

                    RDATA: begin
                        if (scl_rise) begin
                            bit_cnt <= bit_cnt + BIT_CNT_W'(1);
                        end else if (scl_fall) begin
                            if (bit_cnt == FRAME_END) begin
                                state   <= RDATA_ACK;
                                sda_drv <= 1'b1;
                            end else begin
                                sda_drv <= txsh[I2C_DATA_WIDTH-1];
                                txsh    <= {txsh[I2C_DATA_WIDTH-2:0], 1'b0};
                            end
                        end
                    end

                    // Pointer advances past every byte sent, so a later read
                    // resumes after the last byte returned (ACKed or not).
                    RDATA_ACK: begin
                        if (scl_rise) begin
                            mst_ack <= sda;
                            ptr     <= ptr_nxt;
                        end else if (scl_fall) begin
                            bit_cnt <= '0;
                            if (!mst_ack) begin
                                state   <= RDATA;
                                sda_drv <= regs[ptr][I2C_DATA_WIDTH-1];
                                txsh    <= {regs[ptr][I2C_DATA_WIDTH-2:0], 1'b0};
                                if (STRETCH_EN) begin
                                    scl_drv <= 1'b0;
                                    str_cnt <= STR_W'(STRETCH_CYCLES - 1);
                                end
                            end else begin
                                state   <= IGNORE;
                                sda_drv <= 1'b1;
                            end
                        end
                    end

                    IDLE, IGNORE: begin
                        sda_drv <= 1'b1;
                    end

                    default: begin
                        state   <= IDLE;
                        sda_drv <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_slave_regfile.sv
// Bench for i2c_slave_regfile: bit-banged I2C master, behavioural register-file
// model feeding expectation queues, and a monitor comparing DUT responses.
module tb_i2c_slave_regfile;

    localparam int NUM_REGS = 16;
    localparam int SLAVE    = 'h22;
    localparam int Q        = 6;
    localparam int STRETCH  = 20;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    i2c_slave_regfile_if bus();
    logic m_scl = 1'b1;
    logic m_sda = 1'b1;
    assign bus.scl_i = m_scl & bus.scl_o;
    assign bus.sda_i = m_sda & bus.sda_o;

    logic       busy;
    logic       wr_stb;
    logic [3:0] wr_idx;
    logic [7:0] wr_dat;

    i2c_slave_regfile #(
        .I2C_ADDR_WIDTH (7),
        .I2C_DATA_WIDTH (8),
        .SLAVE_ADDR     (7'h22),
        .NUM_REGS       (NUM_REGS),
        .SYNC_STAGES    (2),
        .STRETCH_CYCLES (STRETCH)
    ) dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .bus      (bus),
        .busy_o   (busy),
        .wr_stb_o (wr_stb),
        .wr_idx_o (wr_idx),
        .wr_dat_o (wr_dat)
    );

    int total = 0;
    int bad   = 0;

    typedef struct { int kind; int val; } item_t;
    typedef struct { int idx; int dat; } wr_t;
    item_t exp_q[$];
    item_t obs_q[$];
    wr_t   wr_q[$];

    int mregs [NUM_REGS];
    int mptr  = 0;
    int mbusy = 0;
    int wbytes[$];

    function automatic void check(string name, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic string kind_name(int k);
        case (k)
            0:       return "ack";
            1:       return "rdata";
            default: return "busy";
        endcase
    endfunction

    function automatic void exp_item(int k, int v);
        item_t it;
        it.kind = k;
        it.val  = v;
        exp_q.push_back(it);
    endfunction

    function automatic void obs_item(int k, int v);
        item_t it;
        it.kind = k;
        it.val  = v;
        obs_q.push_back(it);
    endfunction

    // Scoreboard monitor: pair bus observations with expectations, check write strobes.
    always @(negedge clk) begin
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            item_t e;
            item_t o;
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            check(kind_name(e.kind), o.val, e.val);
        end
        if (wr_stb) begin
            if (wr_q.size() == 0) begin
                check("wr_stb_unexpected", 1, 0);
            end else begin
                wr_t w;
                w = wr_q.pop_front();
                check("wr_idx", int'(wr_idx), w.idx);
                check("wr_dat", int'(wr_dat), w.dat);
            end
        end
    end

`ifdef I2C_SLAVE_STRETCH_EN
    int low_cnt = 0;
    // Every self-driven SCL hold must last exactly STRETCH cycles.
    always @(negedge clk) begin
        if (!rst) begin
            if (!bus.scl_o) begin
                low_cnt++;
            end else if (low_cnt != 0) begin
                check("stretch_len", low_cnt, STRETCH);
                low_cnt = 0;
            end
        end
    end
`endif

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic scl_high();
        int t;
        m_scl = 1'b1;
        t = 0;
        while (bus.scl_i !== 1'b1 && t < 2000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 2000) check("scl_release_timeout", 0, 1);
    endtask

    task automatic bit_xfer(input logic b, output logic r, output logic bz);
        wait_cyc(Q);
        m_sda = b;
        wait_cyc(Q);
        scl_high();
        wait_cyc(Q);
        r  = bus.sda_i;
        bz = busy;
        wait_cyc(Q);
        m_scl = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack, output logic bz);
        logic r;
        logic z;
        for (int i = 7; i >= 0; i--) bit_xfer(b[i], r, z);
        bit_xfer(1'b1, ack, bz);
    endtask

    task automatic recv_byte(input logic nack, output logic [7:0] d);
        logic r;
        logic z;
        for (int i = 7; i >= 0; i--) begin
            bit_xfer(1'b1, r, z);
            d[i] = r;
        end
        bit_xfer(nack, r, z);
    endtask

    task automatic i2c_start();
        m_sda = 1'b1;
        wait_cyc(Q);
        scl_high();
        wait_cyc(Q);
        m_sda = 1'b0;
        wait_cyc(2 * Q);
        m_scl = 1'b0;
    endtask

    task automatic i2c_stop();
        wait_cyc(Q);
        m_sda = 1'b0;
        wait_cyc(Q);
        scl_high();
        wait_cyc(Q);
        m_sda = 1'b1;
        wait_cyc(2 * Q);
        mbusy = 0;
    endtask

    // Write transaction: first byte is the pointer, the rest are register data.
    task automatic do_write(input int addr, input bit with_stop);
        logic ack;
        logic bz;
        bit   m;
        m = (addr == SLAVE);
        if (m) mbusy = 1;
        i2c_start();
        exp_item(0, m ? 0 : 1);
        exp_item(2, mbusy);
        send_byte(8'(addr << 1), ack, bz);
        obs_item(0, int'(ack));
        obs_item(2, int'(bz));
        for (int i = 0; i < wbytes.size(); i++) begin
            if (m) begin
                if (i == 0) begin
                    mptr = wbytes[i] % NUM_REGS;
                end else begin
                    wr_t w;
                    w.idx = mptr;
                    w.dat = wbytes[i];
                    wr_q.push_back(w);
                    mregs[mptr] = wbytes[i];
                    mptr = (mptr + 1) % NUM_REGS;
                end
            end
            exp_item(0, m ? 0 : 1);
            send_byte(8'(wbytes[i]), ack, bz);
            obs_item(0, int'(ack));
        end
        if (with_stop) i2c_stop();
    endtask

    // Read transaction: ACK every byte except the last, then STOP.
    task automatic do_read(input int addr, input int n);
        logic       ack;
        logic       bz;
        logic [7:0] d;
        bit         m;
        m = (addr == SLAVE);
        if (m) mbusy = 1;
        i2c_start();
        exp_item(0, m ? 0 : 1);
        exp_item(2, mbusy);
        send_byte(8'((addr << 1) | 1), ack, bz);
        obs_item(0, int'(ack));
        obs_item(2, int'(bz));
        for (int i = 0; i < n; i++) begin
            exp_item(1, m ? mregs[mptr] : 'hFF);
            if (m) mptr = (mptr + 1) % NUM_REGS;
            recv_byte(i == n - 1, d);
            obs_item(1, int'(d));
        end
        i2c_stop();
    endtask

    function automatic int other_addr();
        int a;
        a = int'($urandom_range(0, 127));
        if (a == SLAVE) a = SLAVE + 1;
        return a;
    endfunction

    initial begin
        logic ack;
        logic bz;
        logic r;
        logic z;
        for (int i = 0; i < NUM_REGS; i++) mregs[i] = 0;

        // Reset state
        wait_cyc(3);
        check("rst_scl_o", int'(bus.scl_o), 1);
        check("rst_sda_o", int'(bus.sda_o), 1);
        check("rst_busy", int'(busy), 0);
        check("rst_wr_stb", int'(wr_stb), 0);
        check("rst_wr_idx", int'(wr_idx), 0);
        check("rst_wr_dat", int'(wr_dat), 0);
        rst = 1'b0;
        wait_cyc(10);

        // Pointer 3, then two data bytes
        wbytes = '{'h03, 'hA5, 'h5A};
        do_write(SLAVE, 1'b1);
        check("busy_after_stop", int'(busy), 0);

        // Wrong address: no ACK, no writes, busy stays low
        wbytes = '{'h11, 'h22};
        do_write('h23, 1'b1);

        // Pointer 3, repeated START, read two bytes (ACK, NACK)
        wbytes = '{'h03};
        do_write(SLAVE, 1'b0);
        do_read(SLAVE, 2);
        check("busy_after_read", int'(busy), 0);
        do_read(SLAVE, 1);

        // Pointer wrap from the last register to 0
        wbytes = '{'h0F, 'h11, 'h22};
        do_write(SLAVE, 1'b1);
        wbytes = '{'h0F};
        do_write(SLAVE, 1'b0);
        do_read(SLAVE, 2);

        // Randomized transactions
        for (int it = 0; it < 16; it++) begin
            int sel;
            int n;
            sel = int'($urandom_range(0, 9));
            wbytes.delete();
            if (sel <= 3) begin
                n = int'($urandom_range(0, 3));
                for (int k = 0; k < n; k++) wbytes.push_back(int'($urandom_range(0, 255)));
                do_write(SLAVE, 1'b1);
            end else if (sel <= 6) begin
                wbytes.push_back(int'($urandom_range(0, 255)));
                do_write(SLAVE, 1'b0);
                do_read(SLAVE, int'($urandom_range(1, 3)));
            end else if (sel <= 8) begin
                do_read(SLAVE, int'($urandom_range(1, 3)));
            end else begin
                n = int'($urandom_range(0, 2));
                for (int k = 0; k < n; k++) wbytes.push_back(int'($urandom_range(0, 255)));
                do_write(other_addr(), 1'b1);
            end
        end

        // Reset during the 5th bit of a read byte that drives SDA low
        wbytes = '{7, 'h00};
        do_write(SLAVE, 1'b1);
        wbytes = '{7};
        do_write(SLAVE, 1'b1);
        mbusy = 1;
        i2c_start();
        exp_item(0, 0);
        exp_item(2, 1);
        send_byte(8'((SLAVE << 1) | 1), ack, bz);
        obs_item(0, int'(ack));
        obs_item(2, int'(bz));
        for (int k = 0; k < 4; k++) bit_xfer(1'b1, r, z);
        wait_cyc(Q);
        check("sda_before_rst", int'(bus.sda_o), 0);
        #2 rst = 1'b1;
        #1;
        check("sda_on_rst", int'(bus.sda_o), 1);
        check("scl_on_rst", int'(bus.scl_o), 1);
        check("busy_on_rst", int'(busy), 0);
        for (int i = 0; i < NUM_REGS; i++) mregs[i] = 0;
        mptr  = 0;
        mbusy = 0;
        wait_cyc(3);
        rst = 1'b0;
        wait_cyc(3);
        i2c_stop();
        do_read(SLAVE, 1);

        // Drain and confirm nothing is left unmatched
        wait_cyc(50);
        check("exp_left", exp_q.size(), 0);
        check("obs_left", obs_q.size(), 0);
        check("wr_left", wr_q.size(), 0);
        check("busy_end", int'(busy), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
